// File: rtl/match_pkg.sv
// Shared constants, FSM state encoding and candidate-scoring helper for the
// SRAM matching engine.
package match_pkg;

    localparam int NPORT  = 16;
    localparam int NSRAM  = 32;
    localparam int LANES  = 4;
    localparam int FREE_W = 12;
    localparam int LEN_W  = 9;
    localparam int PORT_W = 4;
    localparam int SRAM_W = $clog2(NSRAM);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SCAN,
        RESULT
    } match_state_t;

    typedef struct packed {
        logic              valid;
        logic              hint;
        logic [FREE_W-1:0] free;
        logic [SRAM_W-1:0] idx;
    } cand_t;

    // True when a should replace b: destination hint, then free space, then lower index.
    function automatic logic better(input cand_t a, input cand_t b);
        if (!a.valid)
            return 1'b0;
        if (!b.valid)
            return 1'b1;
        if (a.hint != b.hint)
            return a.hint;
        if (a.free != b.free)
            return a.free > b.free;
        return a.idx < b.idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or above ptr
// wins, wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable written in always_comb is defaulted first so no latch is inferred.
    always_comb begin
        cand    = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = found ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/sram_match_arbiter.sv
// Grants one write port at a time, scans the SRAM banks LANES per cycle for the
// best target and returns a registered match_end / sram_claim or match_fail pulse.
module sram_match_arbiter
    import match_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        match_enable,
    input  logic [NPORT*LEN_W-1:0]  new_length,
    input  logic [NPORT*PORT_W-1:0] new_dest_port,
    input  logic [NSRAM*FREE_W-1:0] sram_free,
    input  logic [NSRAM-1:0]        sram_busy,
    input  logic [NSRAM*PORT_W-1:0] sram_last_dest,
    output logic [NPORT-1:0]        match_end,
    output logic [SRAM_W-1:0]       match_sram,
    output logic [NSRAM-1:0]        sram_claim,
    output logic                    match_fail
);

    localparam logic [SRAM_W-1:0] LAST_BASE = SRAM_W'(NSRAM - LANES);

    match_state_t      state_q, state_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0] gnt_port_q, gnt_port_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PORT_W-1:0] dest_q, dest_d;
    cand_t             best_q, best_d;
    logic [SRAM_W-1:0] scan_idx_q, scan_idx_d;
    logic [NPORT-1:0]  mask_q, mask_d;
    logic [NPORT-1:0]  match_end_q, match_end_d;
    logic [SRAM_W-1:0] match_sram_q, match_sram_d;
    logic [NSRAM-1:0]  sram_claim_q, sram_claim_d;
    logic              match_fail_q, match_fail_d;

    logic [NPORT-1:0]  arb_gnt;
    logic [PORT_W-1:0] arb_idx;
    logic              req_any;

    // A port served last cycle may not have dropped its request yet.
    rr_arbiter #(
        .N     (NPORT),
        .IDX_W (PORT_W)
    ) u_rr_arbiter (
        .req     (match_enable & ~mask_q),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign req_any = |arb_gnt;

    logic [SRAM_W-1:0] sidx;
    cand_t             lane_c;
    cand_t             lane_best;
    cand_t             merged;

    always_comb begin
        sidx      = '0;
        lane_c    = '0;
        lane_best = '0;
        for (int l = 0; l < LANES; l++) begin
            sidx         = scan_idx_q + SRAM_W'(l);
            lane_c.free  = sram_free[sidx*FREE_W +: FREE_W];
            lane_c.valid = !sram_busy[sidx] &&
                           (lane_c.free >= {{(FREE_W-LEN_W){1'b0}}, len_q});
            lane_c.hint  = (sram_last_dest[sidx*PORT_W +: PORT_W] == dest_q);
            lane_c.idx   = sidx;
            if (better(lane_c, lane_best))
                lane_best = lane_c;
        end
        // Ties keep the register: it always holds the lower index.
        merged = better(lane_best, best_q) ? lane_best : best_q;
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_port_d   = gnt_port_q;
        len_d        = len_q;
        dest_d       = dest_q;
        best_d       = best_q;
        scan_idx_d   = scan_idx_q;
        mask_d       = match_end_q;
        match_end_d  = '0;
        match_sram_d = '0;
        sram_claim_d = '0;
        match_fail_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d    = GRANT;
                    gnt_port_d = arb_idx;
                    len_d      = new_length[arb_idx*LEN_W +: LEN_W];
                    dest_d     = new_dest_port[arb_idx*PORT_W +: PORT_W];
                end
            end
            GRANT: begin
                state_d    = SCAN;
                best_d     = '0;
                scan_idx_d = '0;
            end
            SCAN: begin
                best_d     = merged;
                scan_idx_d = scan_idx_q + SRAM_W'(LANES);
                if (scan_idx_q == LAST_BASE) begin
                    state_d = RESULT;
                    // Outputs are registered, so the final checks happen on the edge into RESULT.
                    if (merged.valid && !sram_busy[merged.idx] && match_enable[gnt_port_q]) begin
                        match_end_d  = NPORT'(1) << gnt_port_q;
                        sram_claim_d = NSRAM'(1) << merged.idx;
                        match_sram_d = merged.idx;
                    end else begin
                        match_fail_d = 1'b1;
                    end
                end
            end
            RESULT: begin
                state_d  = IDLE;
                rr_ptr_d = gnt_port_q + PORT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_port_q   <= '0;
            len_q        <= '0;
            dest_q       <= '0;
            best_q       <= '0;
            scan_idx_q   <= '0;
            mask_q       <= '0;
            match_end_q  <= '0;
            match_sram_q <= '0;
            sram_claim_q <= '0;
            match_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_port_q   <= gnt_port_d;
            len_q        <= len_d;
            dest_q       <= dest_d;
            best_q       <= best_d;
            scan_idx_q   <= scan_idx_d;
            mask_q       <= mask_d;
            match_end_q  <= match_end_d;
            match_sram_q <= match_sram_d;
            sram_claim_q <= sram_claim_d;
            match_fail_q <= match_fail_d;
        end
    end

    assign match_end  = match_end_q;
    assign match_sram = match_sram_q;
    assign sram_claim = sram_claim_q;
    assign match_fail = match_fail_q;

endmodule

// File: tb/tb_sram_match_arbiter.sv
// Directed bench for sram_match_arbiter: latency, scoring, round-robin order,
// no-fit retry, late-busy rejection, grant masking and mid-scan reset.
module tb_sram_match_arbiter;
    import match_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [NPORT-1:0]        match_enable;
    logic [NPORT*LEN_W-1:0]  new_length;
    logic [NPORT*PORT_W-1:0] new_dest_port;
    logic [NSRAM*FREE_W-1:0] sram_free;
    logic [NSRAM-1:0]        sram_busy;
    logic [NSRAM*PORT_W-1:0] sram_last_dest;
    logic [NPORT-1:0]        match_end;
    logic [SRAM_W-1:0]       match_sram;
    logic [NSRAM-1:0]        sram_claim;
    logic                    match_fail;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;
    int pulses;

    sram_match_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .match_enable   (match_enable),
        .new_length     (new_length),
        .new_dest_port  (new_dest_port),
        .sram_free      (sram_free),
        .sram_busy      (sram_busy),
        .sram_last_dest (sram_last_dest),
        .match_end      (match_end),
        .match_sram     (match_sram),
        .sram_claim     (sram_claim),
        .match_fail     (match_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_srams();
        sram_free      = '0;
        sram_busy      = '0;
        sram_last_dest = '0;
    endtask

    task automatic set_sram(input int i, input int free, input int dest);
        sram_free[i*FREE_W +: FREE_W]      = FREE_W'(free);
        sram_last_dest[i*PORT_W +: PORT_W] = PORT_W'(dest);
    endtask

    task automatic raise(input int p, input int len, input int dest);
        new_length[p*LEN_W +: LEN_W]      = LEN_W'(len);
        new_dest_port[p*PORT_W +: PORT_W] = PORT_W'(dest);
        match_enable[p]                   = 1'b1;
    endtask

    // Counts negedges until a match_end or match_fail pulse; bounded.
    task automatic wait_result(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (match_end == '0 && !match_fail && n < 40);
        check({tag, "_seen"}, 64'(match_end != '0 || match_fail), 64'd1);
    endtask

    task automatic check_match(input string tag, input int p, input int s);
        check({tag, "_end"},   64'(match_end),  64'd1 << p);
        check({tag, "_sram"},  64'(match_sram), 64'(s));
        check({tag, "_claim"}, 64'(sram_claim), 64'd1 << s);
        check({tag, "_fail"},  64'(match_fail), 64'd0);
    endtask

    task automatic check_fail(input string tag);
        check({tag, "_fail"},  64'(match_fail), 64'd1);
        check({tag, "_end"},   64'(match_end),  64'd0);
        check({tag, "_claim"}, 64'(sram_claim), 64'd0);
    endtask

    // One isolated request from an idle engine, expected to match at cycle 10.
    task automatic run_single(input string tag, input int p, input int len, input int dest, input int s);
        int n;
        raise(p, len, dest);
        wait_result(tag, n);
        check({tag, "_latency"}, 64'(n), 64'd10);
        check_match(tag, p, s);
        match_enable[p] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        match_enable   = '0;
        new_length     = '0;
        new_dest_port  = '0;
        clear_srams();
        repeat (3) @(negedge clk);
        check("rst_end",   64'(match_end),  64'd0);
        check("rst_claim", 64'(sram_claim), 64'd0);
        check("rst_fail",  64'(match_fail), 64'd0);
        check("rst_sram",  64'(match_sram), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Only SRAM 7 fits length 40.
        clear_srams();
        set_sram(7, 100, 0);
        run_single("single", 3, 40, 2, 7);

        // Destination hint beats free space; without a hint, larger free wins.
        clear_srams();
        set_sram(5, 60, 2);
        set_sram(9, 900, 1);
        run_single("hint_d2", 4, 40, 2, 5);
        run_single("hint_d1", 5, 40, 1, 9);
        run_single("nohint",  6, 40, 3, 9);

        // Equal free, no hint: lower index.
        clear_srams();
        set_sram(4, 200, 0);
        set_sram(12, 200, 0);
        run_single("tie", 7, 40, 2, 4);

        // rr_ptr is 8: port 9 wins first and fails, then the pointer must move past it.
        clear_srams();
        for (int i = 0; i < NSRAM; i++) set_sram(i, 299, 0);
        raise(9, 300, 0);
        raise(2, 10, 0);
        wait_result("nofit", cyc);
        check("nofit_latency", 64'(cyc), 64'd10);
        check_fail("nofit");
        wait_result("rr_after_fail", cyc);
        check_match("rr_after_fail", 2, 0);
        match_enable[2] = 1'b0;
        set_sram(2, 300, 0);
        wait_result("retry", cyc);
        check_match("retry", 9, 2);
        match_enable[9] = 1'b0;
        repeat (2) @(negedge clk);

        // Winner SRAM 7 goes busy during the last scan cycle.
        clear_srams();
        set_sram(7, 100, 0);
        raise(3, 40, 2);
        repeat (9) @(negedge clk);
        check("late_busy_early", 64'(match_end), 64'd0);
        sram_busy[7] = 1'b1;
        @(negedge clk);
        check_fail("late_busy");
        match_enable[3] = 1'b0;
        repeat (2) @(negedge clk);
        sram_busy = '0;

        // Served port keeps its request one extra cycle; it must not be re-granted.
        clear_srams();
        set_sram(0, 500, 0);
        raise(6, 10, 0);
        wait_result("mask", cyc);
        check_match("mask", 6, 0);
        repeat (2) @(negedge clk);
        match_enable[6] = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (match_end != '0 || match_fail) pulses++;
        end
        check("mask_no_regrant", 64'(pulses), 64'd0);

        // Reset in SCAN cycle 5 aborts the round; the held request restarts cleanly.
        raise(11, 10, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_end",   64'(match_end),  64'd0);
        check("midrst_claim", 64'(sram_claim), 64'd0);
        check("midrst_fail",  64'(match_fail), 64'd0);
        check("midrst_sram",  64'(match_sram), 64'd0);
        rst = 1'b0;
        wait_result("regrant", cyc);
        check("regrant_latency", 64'(cyc), 64'd10);
        check_match("regrant", 11, 0);
        match_enable[11] = 1'b0;
        @(negedge clk);

        // Fresh reset puts rr_ptr at 0: order 0, 1, 15, then 0 again.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        raise(0, 10, 0);
        raise(1, 10, 0);
        raise(15, 10, 0);
        wait_result("rr1", cyc);
        check("rr1_latency", 64'(cyc), 64'd10);
        check_match("rr1", 0, 0);
        match_enable[0] = 1'b0;
        wait_result("rr2", cyc);
        check_match("rr2", 1, 0);
        match_enable[1] = 1'b0;
        match_enable[0] = 1'b1;
        wait_result("rr3", cyc);
        check_match("rr3", 15, 0);
        match_enable[15] = 1'b0;
        wait_result("rr4", cyc);
        check_match("rr4", 0, 0);
        match_enable[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_match_arbiter.md
# sram_match_arbiter

Shared matching engine for the write side of the switch. Each port write frontend raises a match request once a packet header (length, destination port) is captured. This block grants one requesting port at a time in round-robin order and scans the SRAM bank status to select a target SRAM. It then pulses `match_end` back to that port together with the chosen SRAM index, so that port's frontend can begin transferring its buffer.

## Interface
Parameters:
- `NPORT`, 16: number of write ports/requesters.
- `NSRAM`, 32: number of SRAM banks.
- `LANES`, 4: SRAMs evaluated per scan cycle; `NSRAM % LANES == 0` required.
- `FREE_W`, 12: width of per-SRAM free-space count (half-words).

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `match_enable` in NPORT: per-port request level, held until `match_end` is seen.
- `new_length` in NPORT*9: packed packet lengths (half-words), port p at [9p+8:9p].
- `new_dest_port` in NPORT*4: packed destination ports.
- `sram_free` in NSRAM*FREE_W: free half-words per SRAM.
- `sram_busy` in NSRAM: SRAM locked by an in-flight packet.
- `sram_last_dest` in NSRAM*4: destination port of the last packet written to each SRAM.
- `match_end` out NPORT: one-hot, one-cycle success pulse to the granted port.
- `match_sram` out 5: selected SRAM index; valid while `match_end != 0`.
- `sram_claim` out NSRAM: one-hot, one-cycle claim pulse, coincident with `match_end`.
- `match_fail` out 1: one-cycle pulse when the scan finds no eligible SRAM or the result is rejected.

## Operation
- FSM states:
  - IDLE → GRANT when any unmasked request is present.
  - GRANT → SCAN (always).
  - SCAN → RESULT after NSRAM/LANES cycles.
  - RESULT → IDLE (always).
- Arbitration (IDLE):
  - Round-robin starting at `rr_ptr`; the lowest index at or above `rr_ptr` wins, wrapping at NPORT-1 → 0.
  - A port that received `match_end` in the previous cycle is masked for that cycle.
- GRANT:
  - Latch `gnt_port`, its length (9b) and dest (4b).
  - Clear the best-candidate register and set `scan_idx` = 0.
- SCAN: each cycle evaluates SRAMs `scan_idx`..`scan_idx`+LANES-1 from the live inputs. An SRAM is eligible iff `!sram_busy` and `sram_free >= {0,length}` (zero-extended to FREE_W).
- Scoring among eligible SRAMs, in priority order:
  1. `sram_last_dest == dest` beats a non-match.
  2. Larger `sram_free` wins.
  3. Lower index wins.
- Best-candidate merge: within a cycle, combinational compare across the lanes; across cycles, compare against the best-candidate register.
- RESULT, success: a candidate exists, `sram_busy[best]` is still 0, and `match_enable[gnt_port]` is still 1. Then:
  - `match_end[gnt_port]` = 1.
  - `sram_claim[best]` = 1.
  - `match_sram` = best.
- RESULT, otherwise: `match_fail` = 1 and no `match_end`. The port keeps requesting and retries in a later round.
- `rr_ptr` update in RESULT: `rr_ptr` ← (`gnt_port`+1) mod NPORT on both success and failure. This gives starvation freedom.

## Timing
- Reset values:
  - State IDLE.
  - `rr_ptr` 0.
  - `match_end`, `sram_claim`, `match_fail` all 0.
  - `match_sram` 0.
  - Best-candidate register invalid.
- Reset mid-scan aborts the scan with no pulses.
- All outputs are registered and asserted only during the RESULT cycle.
- Latency: request visible in IDLE at cycle 0 → GRANT cycle 1 → SCAN cycles 2..9 → RESULT (`match_end`) cycle 10, with defaults. General form: 2 + NSRAM/LANES.
- Throughput: one match per (3 + NSRAM/LANES) cycles, because an IDLE cycle is required between rounds.
- Length and dest are frozen at GRANT; later input changes are ignored.
- `sram_free` and `sram_busy` are sampled at the cycle in which each SRAM is scanned. `sram_busy` of the winner is re-checked in RESULT.
- Simultaneous requests from all ports are served in index order starting from `rr_ptr`.

## Structure
- Package `match_pkg`:
  - Constants NPORT, NSRAM, LANES, FREE_W, LEN_W=9, PORT_W=4.
  - Enum `match_state_t` {IDLE, GRANT, SCAN, RESULT}.
  - Candidate struct {valid, hint, free, idx}.
- One sub-module `rr_arbiter`: NPORT-wide request vector plus pointer in, one-hot grant and index out, combinational.
- The lane-compare tree stays inline.

## Test plan
- Single request: port 3, length 40, dest 2. SRAM 7 is the only one with free ≥ 40 (free 100). → `match_end[3]` and `sram_claim[7]` at cycle 10, `match_sram`=7.
- Hint preference: SRAM 5 (free 60, last_dest 2) vs SRAM 9 (free 900, last_dest 1), dest 2. → picks 5. Same case with dest 1 → picks 9. Equal free and no hint, SRAMs 4 and 12 → picks 4.
- Round-robin: ports 0, 1 and 15 request together with `rr_ptr`=0. → grant order 0, 1, 15, then back to 0 if 0 re-requests. No port is served twice before the others.
- No fit: all SRAMs free < length 300. → `match_fail` pulse, no `match_end`, and `rr_ptr` advances. After raising SRAM 2 free to 300 → port matched to SRAM 2.
- Late busy: the winner's `sram_busy` rises during the last SCAN cycle → `match_fail` in RESULT and no claim.
- Reset asserted in SCAN cycle 5 → all outputs 0 next cycle, state IDLE, `rr_ptr` 0. The pending request is re-granted normally.
